product_accumulator: RTL

Downstream consumer of the 4x4 array multiplier's 8-bit product. Accumulates a stream of unsigned products into a wide accumulator with saturation/overflow tracking and a product counter. On request, snapshots the accumulator and streams it out byte-serially, LSB first, over an 8-bit valid/ready port. Sits between the combinational multiplier and the chip's 8-bit output pins.

---
 rtl/product_accumulator_if.sv | 40 ++++
 rtl/product_accumulator.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/product_accumulator_if.sv
// product_accumulator_if
//   Groups the product input port, the control strobes and the byte-serial
//   readout port of product_accumulator.
//
//   Handshake rules (both ports): a transfer happens on a rising clk edge
//   where valid and ready are both 1. A source holds its data and valid
//   stable until the transfer. prod_ready is combinational. out_valid and
//   out_data are registered and do not depend on out_ready in the same cycle.
//
//   Signals
//     prod_in/prod_valid/prod_ready : 8-bit product stream into the block
//     clear, dump                   : level control strobes, sampled each edge
//     out_data/out_valid/out_ready  : byte-serial readout, LSB byte first
//     acc_ovf, prod_count           : status registers
//     state_dbg                     : 1 while the readout FSM is streaming
interface product_accumulator_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       prod_in;
  logic             prod_valid;
  logic             prod_ready;
  logic             clear;
  logic             dump;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             acc_ovf;
  logic [CNT_W-1:0] prod_count;
  logic             state_dbg;

  modport master (
    output prod_in, prod_valid, clear, dump, out_ready,
    input  prod_ready, out_data, out_valid, acc_ovf, prod_count, state_dbg
  );

  modport slave (
    input  prod_in, prod_valid, clear, dump, out_ready,
    output prod_ready, out_data, out_valid, acc_ovf, prod_count, state_dbg
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator
//   Accumulates a stream of unsigned 8-bit products into an ACC_W-bit
//   accumulator with a sticky overflow flag and a saturating product counter.
//   A dump request snapshots the accumulator and streams it out as ACC_W/8
//   bytes, least significant byte first.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : product_accumulator_if.slave (product input, clear/dump,
//            readout stream, acc_ovf, prod_count, state_dbg)
//
//   Parameters
//     ACC_W    : accumulator width, multiple of 8, at least 16
//     CNT_W    : product counter width (holds at all-ones)
//     SATURATE : 1 = clamp at all-ones on overflow, 0 = wrap
module product_accumulator #(
  parameter int ACC_W    = 16,
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  product_accumulator_if.slave bus
);

  localparam int BEATS = ACC_W / 8;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [ACC_W-1:0] snap, snap_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ovf, ovf_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [IDX_W-1:0] idx_inc;
  logic [7:0]       data_q, data_nx;
  logic             valid_q, valid_nx;
  logic             accept;
  logic [ACC_W:0]   sum;

  // A dump request blocks acceptance in the same cycle so the snapshot is
  // never racing a product being added.
  assign bus.prod_ready = (state == ST_ACC) && !bus.dump && !rst;
  assign accept         = bus.prod_valid && bus.prod_ready;

  // One extra bit catches the carry out for overflow detection.
  assign sum     = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, bus.prod_in};
  assign idx_inc = idx + IDX_W'(1);

  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.acc_ovf    = ovf;
  assign bus.prod_count = cnt;
  assign bus.state_dbg  = (state == ST_SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ACC;
      acc     <= '0;
      snap    <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      idx     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      snap    <= snap_nx;
      cnt     <= cnt_nx;
      ovf     <= ovf_nx;
      idx     <= idx_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    snap_nx  = snap;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    idx_nx   = idx;
    data_nx  = data_q;
    valid_nx = valid_q;

    // Accumulator path. clear wins over the running value; an accept in the
    // clear cycle starts the new run with that product.
    if (bus.clear) begin
      if (accept) begin
        acc_nx = {{(ACC_W - 8){1'b0}}, bus.prod_in};
        cnt_nx = CNT_W'(1);
      end else begin
        acc_nx = '0;
        cnt_nx = '0;
      end
      ovf_nx = 1'b0;
    end else if (accept) begin
      if (sum[ACC_W]) begin
        ovf_nx = 1'b1;
        acc_nx = SATURATE ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
      end else begin
        acc_nx = sum[ACC_W-1:0];
      end
      if (cnt != {CNT_W{1'b1}}) cnt_nx = cnt + CNT_W'(1);
    end

    // Readout FSM. The snapshot uses the current (pre-clear) acc.
    case (state)
      ST_ACC: begin
        if (bus.dump) begin
          snap_nx  = acc;
          idx_nx   = '0;
          data_nx  = acc[7:0];
          valid_nx = 1'b1;
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        if (valid_q && bus.out_ready) begin
          if (idx == LAST_IDX) begin
            valid_nx = 1'b0;
            state_nx = ST_ACC;
          end else begin
            idx_nx  = idx_inc;
            data_nx = snap[{idx_inc, 3'b000} +: 8];
          end
        end
      end
      default: state_nx = ST_ACC;
    endcase
  end

endmodule
